// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter that shares one HPS SD-image channel between NUM_REQ
// block-device requesters, forwarding one sector transaction at a time.
module sd_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LBA_W   = 32,
  parameter int TIMEOUT = 1 << 24
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_rd,
  input  logic [NUM_REQ-1:0]         req_wr,
  input  logic [NUM_REQ*LBA_W-1:0]   req_lba,
  input  logic [NUM_REQ*8-1:0]       req_buff_din,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [NUM_REQ-1:0]         req_buff_wr,
  output logic [NUM_REQ-1:0]         req_err,
  output logic [LBA_W-1:0]           sd_lba,
  output logic                       sd_rd,
  output logic                       sd_wr,
  input  logic                       sd_ack,
  input  logic                       sd_buff_wr,
  output logic [7:0]                 sd_buff_din,
  output logic [$clog2(NUM_REQ)-1:0] grant,
  output logic                       busy,
  output logic [2:0]                 dbg_state
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_XFER    = 3'd2,
    S_RELEASE = 3'd3,
    S_ABORT   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     rr_q, rr_d;
  logic [LBA_W-1:0]  lba_q, lba_d;
  logic              op_rd_q, op_rd_d;
  logic              sd_rd_q, sd_rd_d;
  logic              sd_wr_q, sd_wr_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [NUM_REQ-1:0] pend;
  logic               pick_found;
  logic [GW-1:0]      pick_idx;
  logic [GW-1:0]      scan_idx;
  logic [GW-1:0]      next_ptr;

  assign pend     = req_rd | req_wr;
  assign next_ptr = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  // Scan from the highest offset down so the slot closest to rr_q wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = GW'((int'(rr_q) + k) % NUM_REQ);
      if (pend[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    lba_d       = lba_q;
    op_rd_d     = op_rd_q;
    sd_rd_d     = sd_rd_q;
    sd_wr_d     = sd_wr_q;
    cnt_d       = cnt_q;
    req_ack     = '0;
    req_buff_wr = '0;
    req_err     = '0;
    sd_buff_din = '0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          lba_d   = req_lba[int'(pick_idx)*LBA_W +: LBA_W];
          op_rd_d = req_rd[pick_idx];
          // A stray ack still high keeps the request off the bus until it drops.
          sd_rd_d = req_rd[pick_idx] & ~sd_ack;
          sd_wr_d = ~req_rd[pick_idx] & ~sd_ack;
          cnt_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if ((sd_rd_q | sd_wr_q) && sd_ack) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = S_XFER;
        end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1)) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (!sd_ack) begin
            sd_rd_d = op_rd_q;
            sd_wr_d = ~op_rd_q;
          end
        end
      end
      S_XFER: begin
        req_ack[grant_q]     = sd_ack;
        req_buff_wr[grant_q] = sd_buff_wr & sd_ack;
        sd_buff_din          = req_buff_din[int'(grant_q)*8 +: 8];
        if (!sd_ack) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        rr_d    = next_ptr;
        state_d = S_IDLE;
      end
      S_ABORT: begin
        req_err[grant_q] = 1'b1;
        rr_d             = next_ptr;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      lba_q   <= '0;
      op_rd_q <= 1'b0;
      sd_rd_q <= 1'b0;
      sd_wr_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      lba_q   <= lba_d;
      op_rd_q <= op_rd_d;
      sd_rd_q <= sd_rd_d;
      sd_wr_q <= sd_wr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sd_lba    = lba_q;
  assign sd_rd     = sd_rd_q;
  assign sd_wr     = sd_wr_q;
  assign grant     = grant_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Bench for sd_req_arbiter: directed scenarios plus random traffic, all outputs
// checked every cycle against a transaction-level model of the arbiter.
module tb_sd_req_arbiter;
  localparam int NR = 4;
  localparam int LW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NR-1:0] req_rd = '0, req_wr = '0;
  logic [NR*LW-1:0] req_lba = '0;
  logic [NR*8-1:0]  req_buff_din = '0;
  logic [NR-1:0] req_ack, req_buff_wr, req_err;
  logic [LW-1:0] sd_lba;
  logic          sd_rd, sd_wr;
  logic          sd_ack = 1'b0, sd_buff_wr = 1'b0;
  logic [7:0]    sd_buff_din;
  logic [1:0]    grant;
  logic          busy;
  logic [2:0]    dbg_state;

  sd_req_arbiter #(.NUM_REQ(NR), .LBA_W(LW), .TIMEOUT(TO)) dut (
    .clk_sys(clk), .reset_n(reset_n), .req_rd(req_rd), .req_wr(req_wr),
    .req_lba(req_lba), .req_buff_din(req_buff_din), .req_ack(req_ack),
    .req_buff_wr(req_buff_wr), .req_err(req_err), .sd_lba(sd_lba),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din), .grant(grant), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- requester + HPS drivers ----------------
  bit         want_rd[NR], want_wr[NR], rearm[NR];
  logic [31:0] lba_v[NR];
  logic [7:0]  din_v[NR];
  bit   rand_req = 0, rand_din = 0, hps_rand = 0, hps_off = 0;
  int   hps_delay = 1, hps_len = 4;
  int   hps_ph = 0, hps_cnt = 0, hps_k = 0, hps_n = 0;

  initial begin
    for (int i = 0; i < NR; i++) begin
      want_rd[i] = 0; want_wr[i] = 0; rearm[i] = 0; lba_v[i] = '0; din_v[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (req_ack[i] && !rearm[i]) begin want_rd[i] = 0; want_wr[i] = 0; end
        if (rand_req) begin
          if (!want_rd[i] && !want_wr[i] && !req_ack[i] && $urandom_range(0, 7) == 0) begin
            want_rd[i] = $urandom_range(0, 1) == 1;
            want_wr[i] = !want_rd[i] || $urandom_range(0, 3) == 0;
            lba_v[i]   = $urandom;
            rearm[i]   = $urandom_range(0, 3) == 0;
          end else if (rearm[i] && $urandom_range(0, 15) == 0) rearm[i] = 0;
          else if (want_rd[i] && $urandom_range(0, 63) == 0) want_rd[i] = 0;
        end
        if (rand_din) din_v[i] = 8'($urandom);
        req_rd[i] = want_rd[i] & ~req_ack[i];
        req_wr[i] = want_wr[i] & ~req_ack[i];
        req_lba[i*LW +: LW]    = lba_v[i];
        req_buff_din[i*8 +: 8] = din_v[i];
      end
      case (hps_ph)
        0: begin
          sd_ack = 0; sd_buff_wr = 0;
          if ((sd_rd || sd_wr) && !hps_off) begin
            hps_cnt = hps_rand ? $urandom_range(0, 20) : hps_delay;
            hps_ph  = 1;
          end else if (hps_rand && $urandom_range(0, 63) == 0) begin
            sd_ack = 1; hps_k = 0; hps_n = $urandom_range(1, 4); hps_ph = 2;
          end
        end
        1: begin
          if (hps_cnt == 0) begin
            sd_ack = 1; hps_k = 0; hps_ph = 2;
            hps_n = hps_rand ? $urandom_range(1, 10) : hps_len;
          end else hps_cnt--;
        end
        default: begin
          hps_k++;
          if (hps_k >= hps_n) begin sd_ack = 0; sd_buff_wr = 0; hps_ph = 0; end
          else sd_buff_wr = hps_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
      endcase
    end
  end

  // ---------------- behavioural model ----------------
  // Phases: 0 idle, 1 request on bus / waiting, 2 transfer, 3 release, 4 abort.
  bit         m_valid = 0;
  int         m_ph = 0, m_grant = 0, m_rr = 0, m_wait = 0;
  logic [31:0] m_lba = '0;
  bit         m_rd = 0, m_out = 0;
  logic [1:0] exp_q[$];

  initial begin
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        m_valid = 1; m_ph = 0; m_grant = 0; m_rr = 0; m_wait = 0;
        m_lba = '0; m_rd = 0; m_out = 0; exp_q.delete();
      end else begin
        case (m_ph)
          0: begin
            bit found;
            int w;
            found = 0; w = 0;
            for (int k = 0; k < NR; k++)
              if (!found && (req_rd[(m_rr + k) % NR] || req_wr[(m_rr + k) % NR])) begin
                found = 1; w = (m_rr + k) % NR;
              end
            if (found) begin
              m_grant = w; m_lba = req_lba[w*LW +: LW]; m_rd = req_rd[w];
              m_out = !sd_ack; m_wait = 0; m_ph = 1;
              exp_q.push_back(2'(w));
            end
          end
          1: begin
            if (m_out && sd_ack) begin m_out = 0; m_ph = 2; end
            else if (m_wait == TO - 1) begin m_out = 0; m_ph = 4; end
            else begin m_wait++; if (!sd_ack) m_out = 1; end
          end
          2: if (!sd_ack) m_ph = 3;
          default: begin m_rr = (m_grant + 1) % NR; m_ph = 0; end
        endcase
      end
    end
  end

  // ---------------- compare process + observations ----------------
  int  bw_cnt[NR], err_cnt[NR], ack_cnt[NR];
  int  rd_run = 0;
  int  rd_runs[$];
  logic [1:0] grant_log[$];
  bit  prev_busy = 0;

  task automatic clear_obs();
    for (int i = 0; i < NR; i++) begin bw_cnt[i] = 0; err_cnt[i] = 0; ack_cnt[i] = 0; end
    rd_runs.delete(); grant_log.delete(); rd_run = 0;
  endtask

  initial begin
    logic [NR-1:0] e_ack, e_bw, e_err;
    logic [7:0] e_din;
    clear_obs();
    forever begin
      @(negedge clk);
      #2;
      if (m_valid) begin
        e_ack = '0; e_bw = '0; e_err = '0; e_din = '0;
        if (m_ph == 2) begin
          e_ack[m_grant] = sd_ack;
          e_bw[m_grant]  = sd_ack & sd_buff_wr;
          e_din          = req_buff_din[m_grant*8 +: 8];
        end
        if (m_ph == 4) e_err[m_grant] = 1'b1;
        chk("sd_rd", 64'(sd_rd), 64'(m_out && m_rd));
        chk("sd_wr", 64'(sd_wr), 64'(m_out && !m_rd));
        chk("sd_lba", 64'(sd_lba), 64'(m_lba));
        chk("grant", 64'(grant), 64'(m_grant));
        chk("busy", 64'(busy), 64'(m_ph != 0));
        chk("req_ack", 64'(req_ack), 64'(e_ack));
        chk("req_buff_wr", 64'(req_buff_wr), 64'(e_bw));
        chk("req_err", 64'(req_err), 64'(e_err));
        chk("sd_buff_din", 64'(sd_buff_din), 64'(e_din));
        if (busy && !prev_busy && reset_n) begin
          grant_log.push_back(grant);
          chk("grant_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) chk("grant_order", 64'(grant), 64'(exp_q.pop_front()));
        end
      end
      prev_busy = busy;
      for (int i = 0; i < NR; i++) begin
        bw_cnt[i]  += int'(req_buff_wr[i]);
        err_cnt[i] += int'(req_err[i]);
        ack_cnt[i] += int'(req_ack[i]);
      end
      if (sd_rd) rd_run++;
      else if (rd_run > 0) begin rd_runs.push_back(rd_run); rd_run = 0; end
    end
  end

  // ---------------- directed + random sequence ----------------
  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  task automatic clear_wants();
    for (int i = 0; i < NR; i++) begin want_rd[i] = 0; want_wr[i] = 0; rearm[i] = 0; end
  endtask

  task automatic apply_reset();
    clear_wants();
    reset_n = 0;
    hps_ph = 0;
    repeat (3) tick();
    reset_n = 1;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    int n;
    done = 0;
    repeat (2) tick();
    for (n = 0; n < 600 && !done; n++) begin
      done = !busy && hps_ph == 0 && !sd_ack && req_rd == '0 && req_wr == '0;
      if (!done) tick();
    end
    chk(name, 64'(done), 64'd1);
  endtask

  initial begin
    int n;
    int others;
    reset_n = 0;
    repeat (2) tick();
    chk("rst_sd_rd", 64'(sd_rd), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_lba", 64'(sd_lba), 64'd0);
    reset_n = 1;
    tick();

    // Single read on requester 2
    clear_obs();
    hps_delay = 3; hps_len = 513;
    lba_v[2] = 32'h1234; want_rd[2] = 1;
    for (n = 0; n < 50 && !busy; n++) tick();
    chk("single_busy", 64'(busy), 64'd1);
    chk("single_grant", 64'(grant), 64'd2);
    chk("single_lba", 64'(sd_lba), 64'h1234);
    chk("single_rd", 64'(sd_rd), 64'd1);
    wait_idle("single_idle");
    chk("single_bw512", 64'(bw_cnt[2]), 64'd512);
    others = bw_cnt[0] + bw_cnt[1] + bw_cnt[3] + ack_cnt[0] + ack_cnt[1] + ack_cnt[3];
    chk("single_others", 64'(others), 64'd0);

    // Contention 0,1,3 held and re-asserted
    apply_reset();
    clear_obs();
    hps_delay = 1; hps_len = 4;
    want_rd[0] = 1; want_rd[1] = 1; want_rd[3] = 1;
    rearm[0] = 1; rearm[1] = 1; rearm[3] = 1;
    for (n = 0; n < 400 && grant_log.size() < 6; n++) tick();
    chk("cont_count", 64'(grant_log.size() >= 6), 64'd1);
    if (grant_log.size() >= 6) begin
      chk("cont_g0", 64'(grant_log[0]), 64'd0);
      chk("cont_g1", 64'(grant_log[1]), 64'd1);
      chk("cont_g2", 64'(grant_log[2]), 64'd3);
      chk("cont_g3", 64'(grant_log[3]), 64'd0);
      chk("cont_g4", 64'(grant_log[4]), 64'd1);
      chk("cont_g5", 64'(grant_log[5]), 64'd3);
    end
    clear_wants();
    wait_idle("cont_idle");

    // Read and write together on requester 1: read wins
    want_rd[1] = 1; want_wr[1] = 1;
    for (n = 0; n < 50 && !(sd_rd || sd_wr); n++) tick();
    chk("rdwr_rd", 64'(sd_rd), 64'd1);
    chk("rdwr_wr", 64'(sd_wr), 64'd0);
    chk("rdwr_grant", 64'(grant), 64'd1);
    wait_idle("rdwr_idle");

    // Write on requester 3: write-back byte follows the requester
    hps_len = 10; din_v[3] = 8'hA5; want_wr[3] = 1;
    for (n = 0; n < 50 && !req_ack[3]; n++) tick();
    chk("wr3_ack", 64'(req_ack[3]), 64'd1);
    chk("wr3_din_a5", 64'(sd_buff_din), 64'hA5);
    din_v[3] = 8'h3C;
    repeat (2) tick();
    chk("wr3_din_3c", 64'(sd_buff_din), 64'h3C);
    wait_idle("wr3_idle");

    // Timeout on requester 1, then requester 2 is served
    apply_reset();
    clear_obs();
    hps_off = 1; hps_delay = 2; hps_len = 4;
    want_rd[1] = 1; want_rd[2] = 1;
    for (n = 0; n < 60 && err_cnt[1] == 0; n++) tick();
    chk("to_err1", 64'(err_cnt[1]), 64'd1);
    chk("to_run16", 64'(rd_runs.size() > 0 ? rd_runs[0] : 0), 64'd16);
    hps_off = 0;
    for (n = 0; n < 60 && grant_log.size() < 2; n++) tick();
    chk("to_next", 64'(grant_log.size() >= 2 ? grant_log[1] : 2'd0), 64'd2);
    chk("to_first", 64'(grant_log.size() >= 1 ? grant_log[0] : 2'd0), 64'd1);
    wait_idle("to_idle");
    chk("to_err_once", 64'(err_cnt[1]), 64'd1);

    // Reset in the middle of a transfer, then stray ack
    hps_delay = 1; hps_len = 12; want_rd[0] = 1;
    for (n = 0; n < 50 && !req_ack[0]; n++) tick();
    chk("rx_in_xfer", 64'(req_ack[0]), 64'd1);
    reset_n = 0;
    lba_v[2] = 32'hBEEF; want_rd[2] = 1;
    tick();
    chk("rx_outs", 64'({sd_rd, sd_wr, busy, req_ack, req_buff_wr, req_err}), 64'd0);
    chk("rx_grant", 64'(grant), 64'd0);
    reset_n = 1;
    repeat (2) tick();
    chk("rx_regrant", 64'(grant), 64'd2);
    chk("rx_stray_no_rd", 64'(sd_rd), 64'd0);
    for (n = 0; n < 40 && sd_ack; n++) tick();
    tick();
    chk("rx_rd_after_low", 64'(sd_rd), 64'd1);
    wait_idle("rx_idle");

    // Cancel: write request dropped before the ack
    clear_obs();
    hps_delay = 6; hps_len = 5; want_wr[0] = 1;
    for (n = 0; n < 50 && !sd_wr; n++) tick();
    want_wr[0] = 0;
    tick();
    chk("cancel_hold", 64'(sd_wr), 64'd1);
    for (n = 0; n < 50 && !sd_ack; n++) tick();
    chk("cancel_at_ack", 64'(sd_wr), 64'd1);
    wait_idle("cancel_idle");
    chk("cancel_done", 64'(ack_cnt[0] != 0), 64'd1);

    // Random traffic
    apply_reset();
    rand_req = 1; rand_din = 1; hps_rand = 1;
    repeat (4000) tick();
    rand_req = 0;
    clear_wants();
    wait_idle("rand_drain");
    hps_rand = 0;
    repeat (30) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
